// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch PC generator: reset vector, PC increment
// and next-pc select encodings.
package pc_gen_pkg;

  localparam logic [31:0] INIT_PC = 32'hBFC0_0000;
  localparam int          PC_STEP = 4;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_FLUSH,
    SEL_PEND,
    SEL_BRANCH,
    SEL_SEQ
  } pc_sel_e;

  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/pc_gen_redirect_buffer.sv
// Single-entry buffer for a redirect and a delay-slot tag that arrive while
// the fetch stage is stalled.
module pc_gen_redirect_buffer #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture,
  input  logic [ADDR_W-1:0] capture_addr,
  input  logic              consume,
  input  logic              clear,
  input  logic              ds_set,
  input  logic              ds_clear,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_addr,
  output logic              ds_pend
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      ds_pend    <= 1'b0;
    end else if (clear) begin
      pend_valid <= 1'b0;
      ds_pend    <= 1'b0;
    end else begin
      // ID holds its outputs while stalled, so the first capture is kept.
      if (capture && !pend_valid) begin
        pend_valid <= 1'b1;
        pend_addr  <= capture_addr;
      end else if (consume) begin
        pend_valid <= 1'b0;
      end
      if (ds_set) begin
        ds_pend <= 1'b1;
      end else if (ds_clear) begin
        ds_pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: owns the fetch PC and ROM enable, applies flush,
// stall, buffered and direct branch redirects, and tags delay slots.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(INIT_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              next_inst_delayslot_flag,
  output logic              rom_en,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_adel,
  output logic              if_delayslot
);

  pc_sel_e           sel;
  logic [ADDR_W-1:0] next_pc;
  logic              next_ds;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic              ds_pend;
  logic              live_stall;
  logic              advance;

  assign live_stall = rom_en && !flush && stall;
  assign advance    = rom_en && !flush && !stall;

  pc_gen_redirect_buffer #(.ADDR_W(ADDR_W)) u_rb (
    .clk          (clk),
    .rst_n        (rst_n),
    .capture      (live_stall && branch_flag),
    .capture_addr (branch_addr),
    .consume      (sel == SEL_PEND),
    .clear        (rom_en && flush),
    .ds_set       (live_stall && next_inst_delayslot_flag),
    .ds_clear     (advance),
    .pend_valid   (pend_valid),
    .pend_addr    (pend_addr),
    .ds_pend      (ds_pend)
  );

  always_comb begin
    sel     = SEL_HOLD;
    next_pc = pc;
    next_ds = if_delayslot;
    if (rom_en) begin
      if (flush) begin
        sel     = SEL_FLUSH;
        next_pc = flush_pc;
        next_ds = 1'b0;
      end else if (!stall) begin
        next_ds = next_inst_delayslot_flag | ds_pend;
        // A held redirect beats branch_flag, which is the same request.
        if (pend_valid) begin
          sel     = SEL_PEND;
          next_pc = pend_addr;
        end else if (branch_flag) begin
          sel     = SEL_BRANCH;
          next_pc = branch_addr;
        end else begin
          sel     = SEL_SEQ;
          next_pc = pc + ADDR_W'(PC_STEP);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_en       <= 1'b0;
      pc           <= RESET_PC;
      fetch_adel   <= 1'b0;
      if_delayslot <= 1'b0;
    end else begin
      rom_en       <= 1'b1;
      pc           <= next_pc;
      fetch_adel   <= misaligned(next_pc[1:0]);
      if_delayslot <= next_ds;
    end
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Fetch-side consumer of the ID-stage branch-resolution interface (branch_flag / branch_addr / next_inst_delayslot_flag).
- Owns the architectural fetch PC and drives the instruction-ROM enable.
- Applies ID-stage redirects, exception/flush redirects and pipeline stalls.
- Buffers a redirect that arrives during a stall, and tags the instruction entering ID as a delay-slot instruction.

Parameters:
- RESET_PC, 32'hBFC0_0000, fetch address after reset.
- ADDR_W, 32, PC/address width; must match `ADDR_BUS`.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- stall  input  1  hold the IF stage; PC and tags frozen.
- flush  input  1  exception/eret redirect request.
- flush_pc  input  ADDR_W  redirect target when flush=1.
- branch_flag  input  1  ID stage: take branch this cycle.
- branch_addr  input  ADDR_W  ID stage: branch target.
- next_inst_delayslot_flag  input  1  ID stage: the instruction now in IF is a delay slot.
- rom_en  output  1  instruction-ROM chip enable.
- pc  output  ADDR_W  current fetch address.
- fetch_adel  output  1  pc is misaligned (pc[1:0]!=0); travels with the fetched instruction.
- if_delayslot  output  1  the instruction presented to ID next is in a delay slot.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc=RESET_PC, rom_en=0, fetch_adel=0, if_delayslot=0.
  - pend_valid=0, pend_addr=0.
  - A reset mid-operation discards any pending redirect immediately.
- rom_en:
  - Goes 1 on the first rising edge after rst_n deasserts and stays 1 until the next reset.
  - pc does not change on any edge where rom_en was 0, so the first fetch occurs at RESET_PC.
- Internal state:
  - pend_valid, pend_addr: a single-entry redirect buffer.
  - ds_pend: a single-entry buffer for the delay-slot tag.
- Next-pc selection at each edge with rom_en=1, in priority order:
  1. flush=1: pc<=flush_pc; pend_valid<=0; ds_pend<=0; if_delayslot<=0. Stall is ignored.
  2. stall=1: pc held.
     - If branch_flag=1 and pend_valid=0: pend_valid<=1, pend_addr<=branch_addr.
     - A redirect already pending is never overwritten, because ID holds its outputs constant while stalled.
     - If next_inst_delayslot_flag=1: ds_pend<=1.
     - if_delayslot is held.
  3. pend_valid=1 (stall released): pc<=pend_addr; pend_valid<=0. Any branch_flag seen in the same cycle is ignored, because it is the same held redirect.
  4. branch_flag=1: pc<=branch_addr.
  5. Otherwise: pc<=pc+4, with wrap-around modulo 2^ADDR_W (32'hFFFF_FFFC -> 0).
- Delay-slot tag:
  - On a non-stalled, non-flushed edge: if_delayslot<=next_inst_delayslot_flag | ds_pend, and ds_pend<=0.
- Misaligned fetch:
  - fetch_adel is registered: it equals next_pc[1:0]!=0, computed from the same selection, so it is always coherent with pc.
  - The PC still updates to the misaligned value; exception handling is downstream, and the subsequent flush restores alignment.
- Latency:
  - A branch resolved in ID at edge N is fetched from branch_addr at edge N+1.
  - The delay slot is the instruction at pc during cycle N; it is not squashed.
- Simultaneous events:
  - flush with stall: the flush wins.
  - flush with branch_flag: the flush wins and the branch is dropped.
  - stall with pend_valid=1: pc is held and pending is retained.
- All outputs come from flops; there are no combinational input-to-output paths.

Decomposition:
- Shared header additions:
  - `INIT_PC` (RESET_PC default).
  - `PC_STEP` (4).
  - Encodings for the next-pc select (FLUSH/PEND/BRANCH/SEQ) as localparam-style defines, reused by the stall controller's debug trace.
- One natural sub-module: redirect_buffer.
  - Holds pend_valid/pend_addr/ds_pend.
  - Inputs: capture, consume and clear.
  - Keeps pc_gen to selection logic and the PC register.

Test Plan:
- Reset: hold rst_n=0 3 cycles, release.
  - Expected: pc=32'hBFC0_0000 and rom_en=0 in the first cycle after release; rom_en=1 at the next edge; pc=BFC0_0004 one edge later.
- Taken branch with no stall: pc=0x100, pulse branch_flag=1, branch_addr=0x200, next_inst_delayslot_flag=1.
  - Expected: next pc=0x200, if_delayslot=1 for one cycle, then pc=0x204 and if_delayslot=0.
- Branch during stall: stall=1 for 3 cycles with branch_flag=1, branch_addr=0x400 held.
  - Expected: pc frozen at 0x104 and pend_valid=1; after stall drops, pc=0x400 on the next edge, exactly once, then 0x404.
- Flush beats stall and pending: set pend_valid with addr 0x400, then assert flush=1 and stall=1 with flush_pc=0xBFC0_0380.
  - Expected: pc=0xBFC0_0380, pending cleared; after stall drops, pc=0xBFC0_0384, not 0x400.
- Misaligned and wrap: branch_addr=0x302 gives pc=0x302 with fetch_adel=1 in the same cycle. Separately, pc=0xFFFF_FFFC sequential gives pc=0 and fetch_adel=0.
- Async reset mid-stall with a pending redirect: drop rst_n between edges.
  - Expected: pc=RESET_PC and rom_en=0 immediately, without waiting for an edge; after release, no jump to the stale pend_addr.
